sprite_ram_arbiter: RTL

//  Shares the single-port sprite RAM between the VGA pixel fetch path and an Avalon-MM host port.

---
 rtl/sprite_pkg.sv | 9 +
 rtl/sprite_ram_arbiter.sv | 66 ++++++
 2 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths and enums for the sprite RAM arbiter.
`timescale 1ns/1ps
package sprite_pkg;
  localparam int SPRITE_ADDR_W  = 17;
  localparam int SPRITE_DATA_W  = 3;
  localparam int SPRITE_STALL_W = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIX, OWN_HOST} owner_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_RD_WAIT, ARB_RD_DONE} arb_state_t;
endpackage

// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: shares single-port sprite RAM between pixel fetch (absolute priority) and Avalon host.
`timescale 1ns/1ps
module sprite_ram_arbiter
  import sprite_pkg::*;
#(
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W,
  parameter int STALL_W = SPRITE_STALL_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               pix_req,
  input  logic [ADDR_W-1:0]  pix_addr,
  output logic               pix_valid,
  output logic [DATA_W-1:0]  pix_data,
  input  logic               AVL_CS,
  input  logic               AVL_READ,
  input  logic               AVL_WRITE,
  input  logic [3:0]         AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]  AVL_ADDR,
  input  logic [31:0]        AVL_WRITEDATA,
  output logic [31:0]        AVL_READDATA,
  output logic               AVL_WAITREQUEST,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [STALL_W-1:0] host_stall_cnt
);
  arb_state_t state, state_nx;
  owner_t owner, owner_q;
  logic host_req, host_slot, host_wr;
  logic unused_bits;
  assign unused_bits = ^{AVL_BYTE_EN[3:1], AVL_WRITEDATA[31:DATA_W]};
  assign host_req = AVL_CS & (AVL_READ | AVL_WRITE);
  assign host_wr = AVL_WRITE;
  // The host can only claim the port from IDLE, and never while reset is held.
  assign host_slot = state == ARB_IDLE && host_req && !RESET;
  always_comb begin
    owner = pix_req ? OWN_PIX : host_slot ? OWN_HOST : OWN_NONE;
    ram_addr = owner == OWN_PIX ? pix_addr : owner == OWN_HOST ? AVL_ADDR : '0;
    ram_we = owner == OWN_HOST && host_wr && AVL_BYTE_EN[0];
    ram_wdata = AVL_WRITEDATA[DATA_W-1:0];
    state_nx = state == ARB_RD_WAIT ? ARB_RD_DONE :
               owner == OWN_HOST && !host_wr ? ARB_RD_WAIT : ARB_IDLE;
    AVL_WAITREQUEST = RESET || !((owner == OWN_HOST && host_wr) || state == ARB_RD_DONE);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ARB_IDLE;
      owner_q <= OWN_NONE;
      pix_valid <= 1'b0;
      pix_data <= '0;
      AVL_READDATA <= '0;
      host_stall_cnt <= '0;
    end else begin
      state <= state_nx;
      owner_q <= owner;
      pix_valid <= owner_q == OWN_PIX;
      if (owner_q == OWN_PIX) pix_data <= ram_rdata;
      if (state == ARB_RD_WAIT) AVL_READDATA <= {{(32-DATA_W){1'b0}}, ram_rdata};
      if (state == ARB_IDLE && host_req && pix_req && !(&host_stall_cnt))
        host_stall_cnt <= host_stall_cnt + 1'b1;
    end
  end
endmodule
